// File: rtl/axil_cmd_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axil_cmd_pkg;

    localparam int AXIL_ADDR_W = 8;
    localparam int AXIL_DATA_W = 32;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } state_e;

endpackage

// File: rtl/axil_cmd_master.sv
// Single-command AXI4-Lite initiator: one command in, one bus transaction, one response out.
// Optional hung-slave abort is enabled with `define AXIL_CMD_MASTER_TIMEOUT_EN.
module axil_cmd_master
    import axil_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   control_aclk,
    input  logic                   control_aresetn,

    // Every valid/ready pair below transfers on a clock edge where both are high;
    // a valid driven here never depends combinationally on a ready input and holds
    // its payload until that edge (the timeout abort is the only exception).
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [AXIL_ADDR_W-1:0] cmd_addr,
    input  logic [AXIL_DATA_W-1:0] cmd_wdata,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_write,
    output logic [AXIL_DATA_W-1:0] rsp_rdata,
    output logic [1:0]             rsp_resp,
    output logic                   rsp_timeout,

    output logic [AXIL_ADDR_W-1:0] control_awaddr,
    output logic                   control_awvalid,
    input  logic                   control_awready,
    output logic [AXIL_DATA_W-1:0] control_wdata,
    output logic                   control_wvalid,
    input  logic                   control_wready,
    input  logic [1:0]             control_bresp,
    input  logic                   control_bvalid,
    output logic                   control_bready,
    output logic [AXIL_ADDR_W-1:0] control_araddr,
    output logic                   control_arvalid,
    input  logic                   control_arready,
    input  logic [AXIL_DATA_W-1:0] control_rdata,
    input  logic [1:0]             control_rresp,
    input  logic                   control_rvalid,
    output logic                   control_rready,

    output state_e                 dbg_state
);

    state_e state;
    logic   write_q;
    logic   advance;
    logic   timeout_hit;

    assign dbg_state = state;

    // advance: the current state's exit handshake completes on this edge
    always_comb begin
        advance = 1'b0;
        case (state)
            IDLE:    advance = cmd_valid;
            WR_AW_W: advance = (!control_awvalid || control_awready) &&
                               (!control_wvalid  || control_wready);
            WR_B:    advance = control_bvalid;
            RD_AR:   advance = control_arready;
            RD_R:    advance = control_rvalid;
            RSP:     advance = rsp_ready;
            default: advance = 1'b0;
        endcase
    end

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;
    logic        tmo_flag;
    logic        bus_wait;

    assign bus_wait    = (state == WR_AW_W) || (state == WR_B) ||
                         (state == RD_AR)   || (state == RD_R);
    // A real handshake on the final cycle wins over the abort.
    assign timeout_hit = bus_wait && (tmo_cnt == TMO_LAST) && !advance;
    assign rsp_timeout = tmo_flag;

    always_ff @(posedge control_aclk or negedge control_aresetn) begin
        if (!control_aresetn) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            if (advance || timeout_hit || !bus_wait)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 16'd1;

            if (timeout_hit)
                tmo_flag <= 1'b1;
            else if (state == IDLE && cmd_valid)
                tmo_flag <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge control_aclk or negedge control_aresetn) begin
        if (!control_aresetn) begin
            state           <= IDLE;
            write_q         <= 1'b0;
            cmd_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_write       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_resp        <= OKAY;
            control_awaddr  <= '0;
            control_awvalid <= 1'b0;
            control_wdata   <= '0;
            control_wvalid  <= 1'b0;
            control_bready  <= 1'b0;
            control_araddr  <= '0;
            control_arvalid <= 1'b0;
            control_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        write_q   <= cmd_write;
                        if (cmd_write) begin
                            control_awaddr  <= cmd_addr;
                            control_wdata   <= cmd_wdata;
                            control_awvalid <= 1'b1;
                            control_wvalid  <= 1'b1;
                            state           <= WR_AW_W;
                        end else begin
                            control_araddr  <= cmd_addr;
                            control_arvalid <= 1'b1;
                            state           <= RD_AR;
                        end
                    end
                end
                WR_AW_W: begin
                    if (timeout_hit) begin
                        control_awvalid <= 1'b0;
                        control_wvalid  <= 1'b0;
                        rsp_valid       <= 1'b1;
                        rsp_write       <= write_q;
                        rsp_rdata       <= '0;
                        rsp_resp        <= SLVERR;
                        state           <= RSP;
                    end else begin
                        if (control_awready) control_awvalid <= 1'b0;
                        if (control_wready)  control_wvalid  <= 1'b0;
                        if (advance) begin
                            control_bready <= 1'b1;
                            state          <= WR_B;
                        end
                    end
                end
                WR_B: begin
                    if (timeout_hit || control_bvalid) begin
                        control_bready <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_write      <= write_q;
                        rsp_rdata      <= '0;
                        rsp_resp       <= timeout_hit ? SLVERR : control_bresp;
                        state          <= RSP;
                    end
                end
                RD_AR: begin
                    if (timeout_hit) begin
                        control_arvalid <= 1'b0;
                        rsp_valid       <= 1'b1;
                        rsp_write       <= write_q;
                        rsp_rdata       <= '0;
                        rsp_resp        <= SLVERR;
                        state           <= RSP;
                    end else if (control_arready) begin
                        control_arvalid <= 1'b0;
                        control_rready  <= 1'b1;
                        state           <= RD_R;
                    end
                end
                RD_R: begin
                    if (timeout_hit || control_rvalid) begin
                        control_rready <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_write      <= write_q;
                        rsp_rdata      <= timeout_hit ? '0 : control_rdata;
                        rsp_resp       <= timeout_hit ? SLVERR : control_rresp;
                        state          <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed and randomized bench for axil_cmd_master with a behavioural AXI4-Lite slave.
// Honours AXIL_CMD_MASTER_TIMEOUT_EN for the hung-slave abort scenario.
module tb_axil_cmd_master;
    import axil_cmd_pkg::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    logic [7:0]  control_awaddr;
    logic        control_awvalid;
    logic        control_awready = 1'b0;
    logic [31:0] control_wdata;
    logic        control_wvalid;
    logic        control_wready = 1'b0;
    logic [1:0]  control_bresp = '0;
    logic        control_bvalid = 1'b0;
    logic        control_bready;
    logic [7:0]  control_araddr;
    logic        control_arvalid;
    logic        control_arready = 1'b0;
    logic [31:0] control_rdata = '0;
    logic [1:0]  control_rresp = '0;
    logic        control_rvalid = 1'b0;
    logic        control_rready;
    state_e      dbg_state;

    int total = 0;
    int bad = 0;
    logic aw_done, w_done, ar_done;
    // {write, rdata, resp, timeout}
    logic [35:0] exp_q[$];

    always #5 clk = ~clk;

    axil_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .control_aclk(clk), .control_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .control_awaddr(control_awaddr), .control_awvalid(control_awvalid),
        .control_awready(control_awready),
        .control_wdata(control_wdata), .control_wvalid(control_wvalid),
        .control_wready(control_wready),
        .control_bresp(control_bresp), .control_bvalid(control_bvalid),
        .control_bready(control_bready),
        .control_araddr(control_araddr), .control_arvalid(control_arvalid),
        .control_arready(control_arready),
        .control_rdata(control_rdata), .control_rresp(control_rresp),
        .control_rvalid(control_rvalid), .control_rready(control_rready),
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Command/response side and aw/w/ar slave side sample at negedge+1;
    // b/r slave side at negedge+2 so it sees this cycle's handshake flags.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic tick2();
        @(negedge clk);
        #2;
    endtask

    task automatic check_reset(input string tag);
        check(tag, {cmd_ready, rsp_valid, rsp_write, rsp_resp, rsp_timeout,
                    control_awvalid, control_wvalid, control_bready,
                    control_arvalid, control_rready, control_awaddr, control_araddr},
              {1'b1, 26'd0});
        check(tag, {rsp_rdata, control_wdata}, 64'd0);
        check(tag, dbg_state, IDLE);
    endtask

    task automatic slave_aw(input int dly, input logic [7:0] addr);
        int n = 0;
        while (!control_awvalid && n < 100) begin tick(); n++; end
        check("aw_valid_payload", {control_awvalid, control_awaddr}, {1'b1, addr});
        for (int i = 0; i < dly; i++) begin
            tick();
            check("aw_stall_stable", {control_awvalid, control_awaddr}, {1'b1, addr});
        end
        control_awready = 1'b1;
        aw_done = 1'b1;
        tick();
        control_awready = 1'b0;
        check("aw_dropped", control_awvalid, 1'b0);
    endtask

    task automatic slave_w(input int dly, input logic [31:0] data);
        int n = 0;
        while (!control_wvalid && n < 100) begin tick(); n++; end
        check("w_valid_payload", {control_wvalid, control_wdata}, {1'b1, data});
        for (int i = 0; i < dly; i++) begin
            tick();
            check("w_stall_stable", {control_wvalid, control_wdata}, {1'b1, data});
        end
        control_wready = 1'b1;
        w_done = 1'b1;
        tick();
        control_wready = 1'b0;
        check("w_dropped", control_wvalid, 1'b0);
    endtask

    task automatic slave_b(input int dly, input logic [1:0] resp);
        int n = 0;
        while (!(aw_done && w_done) && n < 200) begin
            tick2();
            check("bready_early", control_bready, 1'b0);
            n++;
        end
        tick2();
        check("bready_up", control_bready, 1'b1);
        for (int i = 0; i < dly; i++) tick2();
        control_bvalid = 1'b1;
        control_bresp  = resp;
        n = 0;
        while (!control_bready && n < 200) begin tick2(); n++; end
        tick2();
        control_bvalid = 1'b0;
        control_bresp  = 2'b00;
    endtask

    task automatic slave_ar(input int dly, input logic [7:0] addr);
        int n = 0;
        while (!control_arvalid && n < 100) begin tick(); n++; end
        check("ar_valid_payload", {control_arvalid, control_araddr}, {1'b1, addr});
        for (int i = 0; i < dly; i++) begin
            tick();
            check("ar_stall_stable", {control_arvalid, control_araddr}, {1'b1, addr});
        end
        control_arready = 1'b1;
        ar_done = 1'b1;
        tick();
        control_arready = 1'b0;
        check("ar_dropped", control_arvalid, 1'b0);
    endtask

    task automatic slave_r(input int dly, input logic [31:0] data, input logic [1:0] resp);
        int n = 0;
        while (!ar_done && n < 200) begin
            tick2();
            check("rready_early", control_rready, 1'b0);
            n++;
        end
        tick2();
        check("rready_up", control_rready, 1'b1);
        for (int i = 0; i < dly; i++) tick2();
        control_rvalid = 1'b1;
        control_rdata  = data;
        control_rresp  = resp;
        n = 0;
        while (!control_rready && n < 200) begin tick2(); n++; end
        tick2();
        control_rvalid = 1'b0;
        control_rdata  = '0;
        control_rresp  = 2'b00;
    endtask

    task automatic master(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                          input int hold, input bit zero_wait);
        int lat;
        logic [35:0] exp;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        tick();
        cmd_valid = 1'b0;
        cmd_write = ~wr;
        cmd_addr  = ~addr;
        cmd_wdata = ~data;
        check("cmd_ready_busy", cmd_ready, 1'b0);
        lat = 1;
        while (!rsp_valid && lat < 200) begin tick(); lat++; end
        check("rsp_seen", rsp_valid, 1'b1);
        if (zero_wait) check("rsp_latency", lat, 3);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hf_ffff_ffff;
        check("rsp_fields", {rsp_write, rsp_rdata, rsp_resp, rsp_timeout}, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("rsp_backpressure", {rsp_valid, cmd_ready, rsp_write, rsp_rdata, rsp_resp, rsp_timeout},
                  {2'b10, exp});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_one_cycle", {rsp_valid, cmd_ready}, 2'b01);
    endtask

    task automatic do_txn(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                          input int a_d, input int w_d, input int resp_d,
                          input logic [31:0] rdata, input logic [1:0] resp, input int hold);
        bit zero_wait;
        zero_wait = (a_d == 0) && (w_d == 0) && (resp_d == 0);
        exp_q.push_back({wr, wr ? 32'd0 : rdata, resp, 1'b0});
        aw_done = 1'b0;
        w_done  = 1'b0;
        ar_done = 1'b0;
        fork
            master(wr, addr, data, hold, zero_wait);
            begin
                if (wr) begin
                    fork
                        slave_aw(a_d, addr);
                        slave_w(w_d, data);
                        slave_b(resp_d, resp);
                    join
                end else begin
                    fork
                        slave_ar(a_d, addr);
                        slave_r(resp_d, rdata, resp);
                    join
                end
            end
        join
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_reset("reset_values");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset("idle_after_release");

        // Zero-wait write, delayed read, skewed write handshakes, back-pressure with SLVERR.
        do_txn(1'b1, 8'h04, 32'hDEADBEEF, 0, 0, 0, 32'h0, 2'b00, 0);
        do_txn(1'b0, 8'h0C, 32'h0, 0, 0, 0, 32'hA5A5_0F0F, 2'b00, 0);
        do_txn(1'b0, 8'h08, 32'h0, 3, 0, 5, 32'h12345678, 2'b00, 0);
        do_txn(1'b1, 8'h10, 32'hCAFE_F00D, 0, 3, 0, 32'h0, 2'b00, 0);
        do_txn(1'b1, 8'h14, 32'h0BAD_BEEF, 1, 1, 2, 32'h0, 2'b10, 6);

        // Reset pulse while the read data phase is pending.
        check("cmd_ready_pre_rst", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h30;
        tick();
        cmd_valid = 1'b0;
        check("rst_arvalid", {control_arvalid, control_araddr}, {1'b1, 8'h30});
        control_arready = 1'b1;
        tick();
        control_arready = 1'b0;
        check("rst_in_rd_r", {control_arvalid, control_rready}, 2'b01);
        #2 rst_n = 1'b0;
        #1 check_reset("reset_async_mid_read");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_reset("reset_released");
        do_txn(1'b0, 8'h30, 32'h0, 0, 0, 0, 32'h7777_1234, 2'b00, 0);

        for (int t = 0; t < 20; t++) begin
            logic wr;
            wr = 1'($urandom_range(0, 1));
            do_txn(wr, 8'($urandom()), $urandom(), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 4), $urandom(), 2'($urandom_range(0, 3)), $urandom_range(0, 3));
        end

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        begin
            int n;
            exp_q.push_back({1'b0, 32'd0, 2'b10, 1'b1});
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = 8'h20;
            tick();
            cmd_valid = 1'b0;
            n = 0;
            while (control_arvalid && n < 100) begin n++; tick(); end
            check("tmo_arvalid_cycles", n, TMO);
            check("tmo_rsp", {rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout},
                  {1'b1, exp_q.pop_front()});
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check("tmo_done", {rsp_valid, cmd_ready}, 2'b01);
            do_txn(1'b1, 8'h24, 32'h1357_9BDF, 0, 0, 0, 32'h0, 2'b00, 0);
        end
`endif

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
